boss_phase_hp: RTL and testbench

BOSS_PHASE_HP -- requirements
Module: boss_phase_hp

---
 rtl/vga_pkg.sv | 11 +
 rtl/boss_iframe_timer.sv | 21 ++
 rtl/boss_phase_hp.sv | 89 ++++++++
 tb/tb_boss_phase_hp.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared display constants; boss section holds FSM states and default HP/damage.
package vga_pkg;
  localparam int BOSS_HGT = 64;
  localparam int BOSS_LNG = 96;
  localparam int BOSS_MAX_HP = 100;
  localparam logic [27:0] BOSS_DMG = {7'd2, 7'd2, 7'd1, 7'd1};
  typedef enum logic [1:0] {IDLE, FIGHT, INVULN, DEAD} boss_state_t;
  function automatic int boss_thresh(input int max_hp, input int n_phase, input int k);
    return max_hp * (n_phase - k) / n_phase;
  endfunction
endpackage

// File: rtl/boss_iframe_timer.sv
// boss_iframe_timer: frame-tick down-counter; done fires on the tick that takes it from 1 to 0.
module boss_iframe_timer #(
  parameter int IFRAMES = 30,
  localparam int CW = $clog2(IFRAMES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic run,
  input  logic frame_tick,
  output logic done
);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (load) cnt <= CW'(IFRAMES);
    else if (run && frame_tick && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign done = run && frame_tick && cnt == CW'(1) && !load;
endmodule

// File: rtl/boss_phase_hp.sv
// boss_phase_hp: boss HP with multi-source damage, remote min-merge, phases and post-phase iframes.
module boss_phase_hp
  import vga_pkg::*;
#(
  parameter int HP_W = 7,
  parameter int MAX_HP = BOSS_MAX_HP,
  parameter int N_SRC = 4,
  parameter logic [N_SRC*HP_W-1:0] DMG = BOSS_DMG,
  parameter int N_PHASE = 3,
  parameter int IFRAMES = 30,
  localparam int DW = HP_W + $clog2(N_SRC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      game_active,
  input  logic            game_start,
  input  logic            frame_tick,
  input  logic [N_SRC-1:0] hit,
  input  logic [HP_W-1:0] remote_hp,
  input  logic            remote_valid,
  output logic [HP_W-1:0] boss_hp,
  output logic            boss_alive,
  output logic [1:0]      boss_phase,
  output logic            invuln,
  output logic            defeated
);
  boss_state_t state;
  logic act, start, live, die, load, done;
  logic [DW-1:0] dmg;
  logic [HP_W-1:0] post, hp_new;
  logic [1:0] ph_calc, ph_new;
  always_comb begin
    act = |game_active;
    start = game_start && act;
    live = state == FIGHT || state == INVULN;
    dmg = '0;
    for (int i = 0; i < N_SRC; i++)
      dmg = dmg + ((hit[i] && state == FIGHT) ? DW'(DMG[i*HP_W +: HP_W]) : DW'(0));
    post = (dmg >= DW'(boss_hp)) ? '0 : boss_hp - dmg[HP_W-1:0];
    hp_new = (remote_valid && remote_hp < post) ? remote_hp : post;
    ph_calc = '0;
    for (int k = 1; k < N_PHASE; k++)
      ph_calc = ph_calc + ((int'(hp_new) <= boss_thresh(MAX_HP, N_PHASE, k)) ? 2'd1 : 2'd0);
    ph_new = (ph_calc > boss_phase) ? ph_calc : boss_phase;
    die = act && live && !start && hp_new == '0;
    load = act && live && !start && hp_new != '0 && ph_new != boss_phase;
  end
  boss_iframe_timer #(.IFRAMES(IFRAMES)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(start || die),
    .load(load),
    .run(act && state == INVULN),
    .frame_tick(frame_tick),
    .done(done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      boss_hp <= HP_W'(MAX_HP);
      boss_phase <= '0;
      boss_alive <= 1'b0;
      invuln <= 1'b0;
      defeated <= 1'b0;
    end else if (start) begin
      state <= FIGHT;
      boss_hp <= HP_W'(MAX_HP);
      boss_phase <= '0;
      boss_alive <= 1'b1;
      invuln <= 1'b0;
      defeated <= 1'b0;
    end else begin
      defeated <= die;
      if (act && live) boss_hp <= hp_new;
      if (die) begin
        state <= DEAD;
        boss_alive <= 1'b0;
        invuln <= 1'b0;
      end else if (load) begin
        state <= INVULN;
        boss_phase <= ph_new;
        invuln <= 1'b1;
      end else if (done) begin
        state <= FIGHT;
        invuln <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_boss_phase_hp.sv
// tb_boss_phase_hp: directed scenarios plus randomized run against a behavioural boss model.
module tb_boss_phase_hp;
  logic clk = 1'b0;
  logic rst, game_start, frame_tick, remote_valid;
  logic [1:0] game_active;
  logic [3:0] hit;
  logic [6:0] remote_hp, boss_hp;
  logic boss_alive, invuln, defeated;
  logic [1:0] boss_phase;
  int checks = 0, errors = 0;
  int m_hp = 100, m_ph = 0, m_fr = 0;
  bit m_alive = 0, m_inv = 0, m_def = 0;
  int dmg_tab[4] = '{1, 1, 2, 2};

  boss_phase_hp dut (
    .clk(clk), .rst(rst), .game_active(game_active), .game_start(game_start),
    .frame_tick(frame_tick), .hit(hit), .remote_hp(remote_hp), .remote_valid(remote_valid),
    .boss_hp(boss_hp), .boss_alive(boss_alive), .boss_phase(boss_phase),
    .invuln(invuln), .defeated(defeated)
  );

  always #5 clk = ~clk;

  function automatic int phase_of(input int hp);
    int p = 0;
    if (hp <= 66) p++;
    if (hp <= 33) p++;
    return p;
  endfunction

  task automatic model(input bit r, input int ga, input bit gs, input bit ft, input bit [3:0] h, input bit rv, input int rh);
    int nh, np;
    if (r) begin
      m_hp = 100; m_ph = 0; m_fr = 0; m_alive = 0; m_inv = 0; m_def = 0;
    end else if (ga != 0 && gs) begin
      m_hp = 100; m_ph = 0; m_fr = 0; m_alive = 1; m_inv = 0; m_def = 0;
    end else begin
      m_def = 0;
      if (ga != 0 && m_alive) begin
        nh = m_hp;
        if (!m_inv) for (int i = 0; i < 4; i++) if (h[i]) nh -= dmg_tab[i];
        if (nh < 0) nh = 0;
        if (rv && rh < nh) nh = rh;
        m_hp = nh;
        np = phase_of(nh) > m_ph ? phase_of(nh) : m_ph;
        if (nh == 0) begin
          m_alive = 0; m_inv = 0; m_fr = 0; m_def = 1;
        end else if (np > m_ph) begin
          m_ph = np; m_inv = 1; m_fr = 30;
        end else if (m_inv && ft) begin
          m_fr--;
          if (m_fr == 0) m_inv = 0;
        end
      end
    end
  endtask

  task automatic step(input bit r, input int ga, input bit gs, input bit ft, input bit [3:0] h, input bit rv, input int rh);
    rst = r; game_active = 2'(ga); game_start = gs; frame_tick = ft;
    hit = h; remote_valid = rv; remote_hp = 7'(rh);
    model(r, ga, gs, ft, h, rv, rh);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 1, 4'hf, 1, 3);
    step(1, 0, 0, 0, 0, 0, 0);
    checks++; if (boss_hp !== 7'd100) begin errors++; $display("FAIL reset_hp: got %0d expected 100", boss_hp); end
    checks++; if (boss_alive !== 1'b0) begin errors++; $display("FAIL reset_alive: got %0b expected 0", boss_alive); end
    checks++; if (boss_phase !== 2'd0 || invuln !== 1'b0 || defeated !== 1'b0) begin errors++;
      $display("FAIL reset_flags: got phase %0d inv %0b def %0b expected 0 0 0", boss_phase, invuln, defeated); end
    step(0, 0, 1, 0, 0, 0, 0);
    checks++; if (boss_alive !== 1'b0) begin errors++; $display("FAIL start_inactive: got alive %0b expected 0", boss_alive); end
  endtask

  task automatic test_start();
    step(0, 1, 1, 0, 0, 0, 0);
    checks++; if (boss_hp !== 7'd100 || boss_alive !== 1'b1 || boss_phase !== 2'd0 || invuln !== 1'b0) begin errors++;
      $display("FAIL start: got hp %0d alive %0b phase %0d inv %0b expected 100 1 0 0", boss_hp, boss_alive, boss_phase, invuln); end
  endtask

  task automatic test_hit_all();
    step(0, 1, 0, 0, 4'b1111, 0, 0);
    checks++; if (boss_hp !== 7'd94) begin errors++; $display("FAIL hit_all: got %0d expected 94", boss_hp); end
  endtask

  task automatic test_iframes();
    step(0, 1, 0, 0, 0, 1, 67);
    checks++; if (boss_hp !== 7'd67 || boss_phase !== 2'd0) begin errors++;
      $display("FAIL load67: got hp %0d phase %0d expected 67 0", boss_hp, boss_phase); end
    step(0, 1, 0, 0, 4'b0001, 0, 0);
    checks++; if (boss_hp !== 7'd66 || boss_phase !== 2'd1 || invuln !== 1'b1) begin errors++;
      $display("FAIL phase1: got hp %0d phase %0d inv %0b expected 66 1 1", boss_hp, boss_phase, invuln); end
    for (int i = 1; i <= 30; i++) begin
      step(0, 1, 0, 1, 4'b1111, 0, 0);
      checks++; if (boss_hp !== 7'd66 || invuln !== (i < 30)) begin errors++;
        $display("FAIL iframe_tick%0d: got hp %0d inv %0b expected 66 %0b", i, boss_hp, invuln, i < 30); end
    end
  endtask

  task automatic test_freeze();
    step(0, 1, 0, 0, 0, 1, 30);
    checks++; if (boss_phase !== 2'd2 || invuln !== 1'b1) begin errors++;
      $display("FAIL freeze_entry: got phase %0d inv %0b expected 2 1", boss_phase, invuln); end
    for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 4'b1111, 1, 5);
    checks++; if (boss_hp !== 7'd30 || invuln !== 1'b1) begin errors++;
      $display("FAIL freeze_hold: got hp %0d inv %0b expected 30 1", boss_hp, invuln); end
    for (int i = 0; i < 29; i++) step(0, 3, 0, 1, 0, 0, 0);
    checks++; if (invuln !== 1'b1) begin errors++; $display("FAIL freeze_count29: got inv %0b expected 1", invuln); end
    step(0, 3, 0, 1, 0, 0, 0);
    checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL freeze_count30: got inv %0b expected 0", invuln); end
  endtask

  task automatic test_multi_phase();
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 90);
    checks++; if (boss_hp !== 7'd90) begin errors++; $display("FAIL remote90: got %0d expected 90", boss_hp); end
    step(0, 1, 0, 0, 0, 1, 95);
    checks++; if (boss_hp !== 7'd90) begin errors++; $display("FAIL remote95_ignored: got %0d expected 90", boss_hp); end
    step(0, 1, 0, 0, 0, 1, 20);
    checks++; if (boss_hp !== 7'd20 || boss_phase !== 2'd2 || invuln !== 1'b1) begin errors++;
      $display("FAIL remote20: got hp %0d phase %0d inv %0b expected 20 2 1", boss_hp, boss_phase, invuln); end
    for (int i = 0; i < 29; i++) step(0, 1, 0, 1, 0, 0, 0);
    checks++; if (invuln !== 1'b1) begin errors++; $display("FAIL single_entry29: got inv %0b expected 1", invuln); end
    step(0, 1, 0, 1, 0, 0, 0);
    checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL single_entry30: got inv %0b expected 0", invuln); end
  endtask

  task automatic test_rst_invuln();
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 60);
    for (int i = 0; i < 18; i++) step(0, 1, 0, 1, 0, 0, 0);
    checks++; if (invuln !== 1'b1 || boss_phase !== 2'd1) begin errors++;
      $display("FAIL pre_rst: got inv %0b phase %0d expected 1 1", invuln, boss_phase); end
    step(1, 1, 1, 1, 4'hf, 1, 2);
    checks++; if (boss_hp !== 7'd100 || invuln !== 1'b0 || boss_alive !== 1'b0 || boss_phase !== 2'd0) begin errors++;
      $display("FAIL rst_invuln: got hp %0d inv %0b alive %0b phase %0d expected 100 0 0 0", boss_hp, invuln, boss_alive, boss_phase); end
  endtask

  task automatic test_death();
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 30; i++) step(0, 1, 0, 1, 0, 0, 0);
    checks++; if (boss_hp !== 7'd1 || invuln !== 1'b0) begin errors++;
      $display("FAIL hp1: got hp %0d inv %0b expected 1 0", boss_hp, invuln); end
    step(0, 1, 0, 0, 4'b0001, 0, 0);
    checks++; if (boss_hp !== 7'd0 || defeated !== 1'b1 || boss_alive !== 1'b0 || invuln !== 1'b0) begin errors++;
      $display("FAIL death: got hp %0d def %0b alive %0b inv %0b expected 0 1 0 0", boss_hp, defeated, boss_alive, invuln); end
    step(0, 1, 0, 0, 4'b1111, 1, 0);
    checks++; if (defeated !== 1'b0 || boss_alive !== 1'b0) begin errors++;
      $display("FAIL death_pulse: got def %0b alive %0b expected 0 0", defeated, boss_alive); end
    step(0, 0, 1, 0, 0, 0, 0);
    checks++; if (boss_alive !== 1'b0) begin errors++; $display("FAIL dead_start_inactive: got alive %0b expected 0", boss_alive); end
    step(0, 2, 1, 0, 0, 0, 0);
    checks++; if (boss_hp !== 7'd100 || boss_phase !== 2'd0 || boss_alive !== 1'b1) begin errors++;
      $display("FAIL restart: got hp %0d phase %0d alive %0b expected 100 0 1", boss_hp, boss_phase, boss_alive); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 299) == 0,
           ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3)),
           $urandom_range(0, 79) == 0,
           $urandom_range(0, 2) == 0,
           4'($urandom),
           $urandom_range(0, 11) == 0,
           int'($urandom_range(0, 110)));
      checks++;
      if (boss_hp !== 7'(m_hp) || boss_phase !== 2'(m_ph) || boss_alive !== m_alive || invuln !== m_inv || defeated !== m_def) begin
        errors++;
        $display("FAIL random_cycle%0d: got hp %0d ph %0d alive %0b inv %0b def %0b expected %0d %0d %0b %0b %0b",
                 n, boss_hp, boss_phase, boss_alive, invuln, defeated, m_hp, m_ph, m_alive, m_inv, m_def);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit_all();
    test_iframes();
    test_freeze();
    test_multi_phase();
    test_rst_invuln();
    test_death();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
